// File: rtl/alu_muldiv_ctrl.sv
// alu_muldiv_ctrl: ALU control decode plus an iterative mult/div sequencer with
// HI/LO registers for the EX stage of the MIPS datapath.
// Optional feature: define MULDIV_SIGNED_EN to make mult/div (funct 011000 /
// 011010) operate on signed operands. When undefined, they behave as multu/divu.
module alu_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [3:0]       alu_control,
    output logic             stall,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    localparam logic [5:0] F_MTHI = 6'b010001;
    localparam logic [5:0] F_MTLO = 6'b010011;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10
    } state_t;

    state_t state_reg, state_next;

    // Sequencer datapath registers
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] acc_reg;      // mult: running high half; div: partial remainder
    logic [WIDTH-1:0] q_reg;        // mult: multiplier / low half; div: dividend -> quotient
    logic [WIDTH-1:0] opd_reg;      // multiplicand or divisor magnitude
    logic             neg_lo_reg;   // negate product / quotient at the end
    logic             neg_hi_reg;   // negate remainder at the end
    logic             divz_reg;     // divisor was zero
    logic [WIDTH-1:0] rs_reg;       // original dividend for the divide-by-zero result
    logic [WIDTH-1:0] hi_reg, lo_reg;
    logic             md_done_reg;

    // Decode / control
    logic md_group, md_req, md_act, busy, last_step;
    logic issue_mul, issue_div, wr_hi, wr_lo;
    logic op_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    // Step results
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_next, mul_lo_next;
    logic [WIDTH:0]     r_shift;
    logic [WIDTH+1:0]   diff_ext;
    logic               borrow;
    logic [WIDTH-1:0]   div_r_next, div_q_next;
    logic [2*WIDTH-1:0] product, prod_fix;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic               unused_diff_msb;

    // ALU control decode; alu_op 00 wins over x1, which wins over R-type funct
    always_comb begin
        alu_control = 4'b0000;
        if (alu_op == 2'b00) begin
            alu_control = 4'b0010;
        end else if (alu_op[0]) begin
            alu_control = 4'b0110;
        end else begin
            case (funct)
                6'b100000, 6'b100001: alu_control = 4'b0010;
                6'b100010, 6'b100011: alu_control = 4'b0110;
                6'b100100:            alu_control = 4'b0000;
                6'b100101:            alu_control = 4'b0001;
                6'b100110:            alu_control = 4'b0011;
                6'b100111:            alu_control = 4'b1100;
                6'b101010:            alu_control = 4'b0111;
                6'b101011:            alu_control = 4'b1111;
                6'b000000:            alu_control = 4'b1000;
                6'b000010:            alu_control = 4'b1001;
                6'b000011:            alu_control = 4'b1010;
                default:              alu_control = 4'b0000;
            endcase
        end
    end

    // Mult/div group: 0110xx (mult/multu/div/divu) and 0100xx (mfhi/mthi/mflo/mtlo)
    assign md_group  = (funct[5:2] == 4'b0110) || (funct[5:2] == 4'b0100);
    assign md_req    = en & alu_op[1] & md_group;
    assign md_act    = md_req & ~busy;
    assign issue_mul = md_act & (funct[5:1] == 5'b01100);
    assign issue_div = md_act & (funct[5:1] == 5'b01101);
    assign wr_hi     = md_act & (funct == F_MTHI);
    assign wr_lo     = md_act & (funct == F_MTLO);

`ifdef MULDIV_SIGNED_EN
    // funct[0]==0 selects the signed variant (mult / div)
    assign op_signed = ~funct[0];
`else
    assign op_signed = 1'b0;
`endif

    assign a_neg = op_signed & rs_val[WIDTH-1];
    assign b_neg = op_signed & rt_val[WIDTH-1];
    assign a_mag = a_neg ? (~rs_val + 1'b1) : rs_val;
    assign b_mag = b_neg ? (~rt_val + 1'b1) : rt_val;

    // One shift-add multiply step: add multiplicand when the multiplier LSB is set, shift right
    assign mul_sum     = {1'b0, acc_reg} + (q_reg[0] ? {1'b0, opd_reg} : {(WIDTH+1){1'b0}});
    assign mul_hi_next = mul_sum[WIDTH:1];
    assign mul_lo_next = {mul_sum[0], q_reg[WIDTH-1:1]};

    // One restoring divide step: shift in next dividend bit, subtract if it fits
    assign r_shift    = {acc_reg, q_reg[WIDTH-1]};
    assign diff_ext   = {1'b0, r_shift} - {2'b00, opd_reg};
    assign borrow     = diff_ext[WIDTH+1];
    assign div_r_next = borrow ? r_shift[WIDTH-1:0] : diff_ext[WIDTH-1:0];
    assign div_q_next = {q_reg[WIDTH-2:0], ~borrow};
    // The remainder never exceeds the divisor, so this difference bit carries no information
    assign unused_diff_msb = diff_ext[WIDTH];

    // Final-edge result with sign fixup folded in
    assign product  = {mul_hi_next, mul_lo_next};
    assign prod_fix = neg_lo_reg ? (~product + 1'b1) : product;

    always_comb begin
        res_hi = prod_fix[2*WIDTH-1:WIDTH];
        res_lo = prod_fix[WIDTH-1:0];
        if (state_reg == DIV) begin
            if (divz_reg) begin
                res_hi = rs_reg;
                res_lo = {WIDTH{1'b1}};
            end else begin
                res_hi = neg_hi_reg ? (~div_r_next + 1'b1) : div_r_next;
                res_lo = neg_lo_reg ? (~div_q_next + 1'b1) : div_q_next;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state: start on issue, return to IDLE after the last iteration
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (issue_mul) begin
                    state_next = MUL;
                end else if (issue_div) begin
                    state_next = DIV;
                end
            end
            MUL, DIV: begin
                if (last_step) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: busy, stall toward the hazard unit, final-iteration flag
    always_comb begin
        busy      = (state_reg != IDLE);
        last_step = busy && (cnt_reg == LAST_STEP);
        stall     = md_req & busy;
    end

    // Sequencer datapath: capture magnitudes on issue, iterate while busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg    <= '0;
            acc_reg    <= '0;
            q_reg      <= '0;
            opd_reg    <= '0;
            neg_lo_reg <= 1'b0;
            neg_hi_reg <= 1'b0;
            divz_reg   <= 1'b0;
            rs_reg     <= '0;
        end else if (state_reg == IDLE) begin
            if (issue_mul || issue_div) begin
                cnt_reg    <= '0;
                acc_reg    <= '0;
                q_reg      <= a_mag;
                opd_reg    <= b_mag;
                neg_lo_reg <= a_neg ^ b_neg;
                neg_hi_reg <= a_neg;
                divz_reg   <= (rt_val == '0);
                rs_reg     <= rs_val;
            end
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
            if (state_reg == MUL) begin
                acc_reg <= mul_hi_next;
                q_reg   <= mul_lo_next;
            end else begin
                acc_reg <= div_r_next;
                q_reg   <= div_q_next;
            end
        end
    end

    // HI/LO: results on the final iteration, moves only while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (last_step) begin
            hi_reg <= res_hi;
            lo_reg <= res_lo;
        end else begin
            if (wr_hi) begin
                hi_reg <= rs_val;
            end
            if (wr_lo) begin
                lo_reg <= rs_val;
            end
        end
    end

    // Completion pulse, high for the cycle after HI/LO are written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_done_reg <= 1'b0;
        end else begin
            md_done_reg <= last_step;
        end
    end

    assign hi      = hi_reg;
    assign lo      = lo_reg;
    assign md_done = md_done_reg;

endmodule
